build_mem_arbiter: RTL and testbench

BUILD_MEM_ARBITER -- requirements
Module: build_mem_arbiter

---
 rtl/build_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_build_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/build_mem_arbiter.sv
// Memory-request arbiter for the hash-join build stage: merges the LL, HT and UPD
// request streams onto one memory port and routes memory responses back.

module build_mem_arbiter_fifo #(
    parameter int W      = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 12,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          afull,
    output logic          dropped
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [W-1:0]  rd_data_reg;
    logic          afull_reg;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && (count_reg != CW'(DEPTH));
    assign dropped = push && (count_reg == CW'(DEPTH)) && !rst;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + CW'(1);
        else if (do_pop && !do_push)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    // afull is computed from the next count so the flag lines up with count itself
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
            afull_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            afull_reg <= (count_next >= CW'(THRESH));
            if (do_push)
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            if (do_pop) begin
                rd_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;
    assign afull   = afull_reg;
endmodule

module build_mem_arbiter #(
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic        clk,
    input  logic        rst,
    output logic        done,
    output logic        ll_afull_out,
    input  logic        ll_write_en_in,
    input  logic [47:0] ll_address_in,
    input  logic [63:0] ll_payload_in,
    output logic        ht_rq_afull_out,
    input  logic        ht_rq_read_en_in,
    input  logic [47:0] ht_rq_address_in,
    input  logic [63:0] ht_rq_data_in,
    output logic        ll_update_afull_out,
    input  logic        ll_update_write_en_in,
    input  logic [47:0] ll_update_addr_in,
    input  logic [63:0] ll_update_data_in,
    input  logic        ht_rs_afull_in,
    output logic        ht_rs_write_en_out,
    output logic [63:0] ht_rs_data_out,
    output logic        ll_rs_write_en_out,
    input  logic        mc_rq_stall_in,
    output logic        mc_rq_vld_out,
    output logic [1:0]  mc_rq_cmd_out,
    output logic [1:0]  mc_rq_rtnctl_out,
    output logic [47:0] mc_rq_vadr_out,
    output logic [63:0] mc_rq_data_out,
    input  logic        mc_rs_vld_in,
    input  logic [1:0]  mc_rs_rtnctl_in,
    input  logic [63:0] mc_rs_data_in,
    output logic        mc_rs_stall_out,
    output logic        overflow_out
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = 112;
    localparam logic [1:0] ID_LL    = 2'd0;
    localparam logic [1:0] ID_HT    = 2'd1;
    localparam logic [1:0] ID_UPD   = 2'd2;
    localparam logic [1:0] CMD_WR   = 2'd1;
    localparam logic [1:0] CMD_XCHG = 2'd2;

    logic [2:0]    req_push, req_pop, req_afull, req_drop, elig;
    logic [RW-1:0] req_wdata [3];
    logic [RW-1:0] req_rdata [3];
    logic [CW-1:0] req_count [3];
    logic [CW-1:0] rsp_count;
    logic          rsp_drop, rsp_push, rs_accept, ht_room, ht_issue;
    logic [9:0]    inflight_reg, ht_inflight_reg;
    logic [1:0]    rr_reg, grant_id, rq_sel_reg, rq_cmd_reg;
    logic          grant_vld, rq_vld_reg, ll_rs_reg, rs_we_reg, overflow_reg;
    logic [RW-1:0] rq_entry;

    assign req_push     = {ll_update_write_en_in, ht_rq_read_en_in, ll_write_en_in};
    assign req_wdata[0] = {ll_address_in, ll_payload_in};
    assign req_wdata[1] = {ht_rq_address_in, ht_rq_data_in};
    assign req_wdata[2] = {ll_update_addr_in, ll_update_data_in};

    // HT may only issue while every outstanding exchange still has a response slot
    assign ht_room = (11'(ht_inflight_reg) + 11'(rsp_count)) < 11'(FIFO_DEPTH);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            build_mem_arbiter_fifo #(
                .W(RW), .DEPTH(FIFO_DEPTH), .THRESH(AFULL_THRESH), .CW(CW)
            ) u_fifo (
                .clk(clk), .rst(rst),
                .push(req_push[gi]), .push_data(req_wdata[gi]),
                .pop(req_pop[gi]), .rd_data(req_rdata[gi]),
                .count(req_count[gi]), .afull(req_afull[gi]), .dropped(req_drop[gi])
            );
            assign elig[gi]    = (req_count[gi] != '0) && ((gi != 1) || ht_room);
            assign req_pop[gi] = grant_vld && (grant_id == 2'(gi));
        end
    endgenerate

    function automatic logic [1:0] rr_add(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 3)
            s = s - 3;
        return s[1:0];
    endfunction

    // Lowest offset from the round-robin pointer wins
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_reg;
        for (int k = 2; k >= 0; k--) begin
            if (!mc_rq_stall_in && !rst && elig[rr_add(rr_reg, k)]) begin
                grant_vld = 1'b1;
                grant_id  = rr_add(rr_reg, k);
            end
        end
    end

    assign ht_issue  = grant_vld && (grant_id == ID_HT);
    assign rs_accept = mc_rs_vld_in && (inflight_reg != '0) && !rst;
    assign rsp_push  = rs_accept && (mc_rs_rtnctl_in == ID_HT) && (ht_inflight_reg != '0);

    build_mem_arbiter_fifo #(
        .W(64), .DEPTH(FIFO_DEPTH), .THRESH(AFULL_THRESH), .CW(CW)
    ) u_rsp_fifo (
        .clk(clk), .rst(rst),
        .push(rsp_push), .push_data(mc_rs_data_in),
        .pop(!ht_rs_afull_in), .rd_data(ht_rs_data_out),
        .count(rsp_count), .afull(mc_rs_stall_out), .dropped(rsp_drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg          <= ID_LL;
            rq_vld_reg      <= 1'b0;
            rq_sel_reg      <= ID_LL;
            rq_cmd_reg      <= 2'd0;
            inflight_reg    <= '0;
            ht_inflight_reg <= '0;
            ll_rs_reg       <= 1'b0;
            rs_we_reg       <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            rq_vld_reg <= grant_vld;
            if (grant_vld) begin
                rq_sel_reg <= grant_id;
                rq_cmd_reg <= (grant_id == ID_HT) ? CMD_XCHG : CMD_WR;
                rr_reg     <= (grant_id == ID_UPD) ? ID_LL : grant_id + 2'd1;
            end
            // Late responses after reset find a zero count and are ignored
            if (grant_vld && !rs_accept)
                inflight_reg <= inflight_reg + 10'd1;
            else if (!grant_vld && rs_accept)
                inflight_reg <= inflight_reg - 10'd1;
            if (ht_issue && !rsp_push)
                ht_inflight_reg <= ht_inflight_reg + 10'd1;
            else if (!ht_issue && rsp_push)
                ht_inflight_reg <= ht_inflight_reg - 10'd1;
            ll_rs_reg <= rs_accept && (mc_rs_rtnctl_in == ID_UPD);
            rs_we_reg <= (rsp_count != '0) && !ht_rs_afull_in;
            if ((|req_drop) || rsp_drop)
                overflow_reg <= 1'b1;
        end
    end

    always_comb begin
        rq_entry = '0;
        case (rq_sel_reg)
            ID_LL:   rq_entry = req_rdata[0];
            ID_HT:   rq_entry = req_rdata[1];
            ID_UPD:  rq_entry = req_rdata[2];
            default: rq_entry = '0;
        endcase
    end

    assign {mc_rq_vadr_out, mc_rq_data_out} = rq_entry;
    assign mc_rq_vld_out       = rq_vld_reg;
    assign mc_rq_cmd_out       = rq_cmd_reg;
    assign mc_rq_rtnctl_out    = rq_sel_reg;
    assign ht_rs_write_en_out  = rs_we_reg;
    assign ll_rs_write_en_out  = ll_rs_reg;
    assign overflow_out        = overflow_reg;
    assign ll_afull_out        = req_afull[0];
    assign ht_rq_afull_out     = req_afull[1];
    assign ll_update_afull_out = req_afull[2];

    assign done = (req_count[0] == '0) && (req_count[1] == '0) && (req_count[2] == '0) &&
                  (rsp_count == '0) && (inflight_reg == '0) && !rq_vld_reg && !rs_we_reg;
endmodule

// File: tb/tb_build_mem_arbiter.sv
// Directed bench for build_mem_arbiter: issue order, stall, overflow, HT response
// back-pressure and mid-operation reset.
module tb_build_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        done;
    logic        ll_afull_out, ll_write_en_in;
    logic [47:0] ll_address_in;
    logic [63:0] ll_payload_in;
    logic        ht_rq_afull_out, ht_rq_read_en_in;
    logic [47:0] ht_rq_address_in;
    logic [63:0] ht_rq_data_in;
    logic        ll_update_afull_out, ll_update_write_en_in;
    logic [47:0] ll_update_addr_in;
    logic [63:0] ll_update_data_in;
    logic        ht_rs_afull_in, ht_rs_write_en_out;
    logic [63:0] ht_rs_data_out;
    logic        ll_rs_write_en_out;
    logic        mc_rq_stall_in, mc_rq_vld_out;
    logic [1:0]  mc_rq_cmd_out, mc_rq_rtnctl_out;
    logic [47:0] mc_rq_vadr_out;
    logic [63:0] mc_rq_data_out;
    logic        mc_rs_vld_in;
    logic [1:0]  mc_rs_rtnctl_in;
    logic [63:0] mc_rs_data_in;
    logic        mc_rs_stall_out, overflow_out;

    build_mem_arbiter #(.FIFO_DEPTH(16), .AFULL_THRESH(12)) dut (
        .clk(clk), .rst(rst), .done(done),
        .ll_afull_out(ll_afull_out), .ll_write_en_in(ll_write_en_in),
        .ll_address_in(ll_address_in), .ll_payload_in(ll_payload_in),
        .ht_rq_afull_out(ht_rq_afull_out), .ht_rq_read_en_in(ht_rq_read_en_in),
        .ht_rq_address_in(ht_rq_address_in), .ht_rq_data_in(ht_rq_data_in),
        .ll_update_afull_out(ll_update_afull_out), .ll_update_write_en_in(ll_update_write_en_in),
        .ll_update_addr_in(ll_update_addr_in), .ll_update_data_in(ll_update_data_in),
        .ht_rs_afull_in(ht_rs_afull_in), .ht_rs_write_en_out(ht_rs_write_en_out),
        .ht_rs_data_out(ht_rs_data_out), .ll_rs_write_en_out(ll_rs_write_en_out),
        .mc_rq_stall_in(mc_rq_stall_in), .mc_rq_vld_out(mc_rq_vld_out),
        .mc_rq_cmd_out(mc_rq_cmd_out), .mc_rq_rtnctl_out(mc_rq_rtnctl_out),
        .mc_rq_vadr_out(mc_rq_vadr_out), .mc_rq_data_out(mc_rq_data_out),
        .mc_rs_vld_in(mc_rs_vld_in), .mc_rs_rtnctl_in(mc_rs_rtnctl_in),
        .mc_rs_data_in(mc_rs_data_in), .mc_rs_stall_out(mc_rs_stall_out),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [1:0]  rtn;
        logic [47:0] adr;
        logic [63:0] dat;
    } iss_t;

    iss_t        iss_q[$];
    logic [63:0] rsd_q[$];

    // Transaction monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mc_rq_vld_out) begin
            iss_q.push_back({mc_rq_cmd_out, mc_rq_rtnctl_out, mc_rq_vadr_out, mc_rq_data_out});
            $display("ISSUE cmd=%0d rtnctl=%0d vadr=%0h data=%0h", mc_rq_cmd_out,
                     mc_rq_rtnctl_out, mc_rq_vadr_out, mc_rq_data_out);
        end
        if (ht_rs_write_en_out) begin
            rsd_q.push_back(ht_rs_data_out);
            $display("HT_RS data=%0h", ht_rs_data_out);
        end
        if (ll_rs_write_en_out)
            $display("LL_RS pulse");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base, rbase, pushed, resp_n;
        rst = 1'b1;
        ll_write_en_in = 0; ll_address_in = '0; ll_payload_in = '0;
        ht_rq_read_en_in = 0; ht_rq_address_in = '0; ht_rq_data_in = '0;
        ll_update_write_en_in = 0; ll_update_addr_in = '0; ll_update_data_in = '0;
        ht_rs_afull_in = 0; mc_rq_stall_in = 0;
        mc_rs_vld_in = 0; mc_rs_rtnctl_in = '0; mc_rs_data_in = '0;
        tick();
        tick();
        check("rst_done", done, 1);
        check("rst_vld", mc_rq_vld_out, 0);
        check("rst_ovf", overflow_out, 0);
        check("rst_stall", mc_rs_stall_out, 0);
        rst = 1'b0;

        // Single LL write round trip
        ll_write_en_in = 1; ll_address_in = 48'h100; ll_payload_in = 64'hAA;
        tick();
        ll_write_en_in = 0;
        check("t1_vld_early", mc_rq_vld_out, 0);
        check("t1_done_queued", done, 0);
        tick();
        check("t1_vld", mc_rq_vld_out, 1);
        check("t1_cmd", mc_rq_cmd_out, 1);
        check("t1_rtn", mc_rq_rtnctl_out, 0);
        check("t1_adr", mc_rq_vadr_out, 64'h100);
        check("t1_dat", mc_rq_data_out, 64'hAA);
        tick();
        check("t1_vld_once", mc_rq_vld_out, 0);
        repeat (3) tick();
        check("t1_done_wait", done, 0);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd0;
        tick();
        mc_rs_vld_in = 0;
        check("t1_done_after", done, 1);

        // All three streams at once, from a fresh round-robin pointer
        do_reset();
        ll_write_en_in = 1; ll_address_in = 48'h200; ll_payload_in = 64'h11;
        ht_rq_read_en_in = 1; ht_rq_address_in = 48'h300; ht_rq_data_in = 64'h22;
        ll_update_write_en_in = 1; ll_update_addr_in = 48'h400; ll_update_data_in = 64'h33;
        tick();
        ll_write_en_in = 0; ht_rq_read_en_in = 0; ll_update_write_en_in = 0;
        tick();
        check("t2_ll_rtn", mc_rq_rtnctl_out, 0);
        check("t2_ll_adr", mc_rq_vadr_out, 64'h200);
        tick();
        check("t2_ht_vld", mc_rq_vld_out, 1);
        check("t2_ht_rtn", mc_rq_rtnctl_out, 1);
        check("t2_ht_cmd", mc_rq_cmd_out, 2);
        check("t2_ht_dat", mc_rq_data_out, 64'h22);
        tick();
        check("t2_upd_rtn", mc_rq_rtnctl_out, 2);
        check("t2_upd_cmd", mc_rq_cmd_out, 1);
        check("t2_upd_adr", mc_rq_vadr_out, 64'h400);
        tick();
        check("t2_idle", mc_rq_vld_out, 0);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd1; mc_rs_data_in = 64'h55;
        tick();
        mc_rs_vld_in = 0;
        check("t2_htrs_early", ht_rs_write_en_out, 0);
        tick();
        check("t2_htrs_we", ht_rs_write_en_out, 1);
        check("t2_htrs_dat", ht_rs_data_out, 64'h55);
        tick();
        check("t2_htrs_once", ht_rs_write_en_out, 0);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd2;
        tick();
        mc_rs_vld_in = 0;
        check("t2_llrs", ll_rs_write_en_out, 1);
        tick();
        check("t2_llrs_once", ll_rs_write_en_out, 0);
        check("t2_done_pending", done, 0);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd0;
        tick();
        mc_rs_vld_in = 0;
        check("t2_done", done, 1);

        // 13 LL pushes under a 20-cycle stall
        base = iss_q.size();
        mc_rq_stall_in = 1;
        for (int i = 0; i < 13; i++) begin
            ll_write_en_in = 1; ll_address_in = 48'h1000 + 48'(i); ll_payload_in = 64'h5000 + 64'(i);
            tick();
            if (i == 10) check("t3_afull_11", ll_afull_out, 0);
            if (i == 11) check("t3_afull_12", ll_afull_out, 1);
        end
        ll_write_en_in = 0;
        repeat (7) tick();
        check("t3_no_issue", 64'(iss_q.size() - base), 0);
        mc_rq_stall_in = 0;
        repeat (16) tick();
        check("t3_issued", 64'(iss_q.size() - base), 13);
        for (int k = 0; k < 13 && base + k < iss_q.size(); k++)
            check($sformatf("t3_adr%0d", k), 64'(iss_q[base + k].adr), 64'h1000 + 64'(k));
        check("t3_afull_clr", ll_afull_out, 0);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd0;
        repeat (13) tick();
        mc_rs_vld_in = 0;
        check("t3_done", done, 1);

        // 17 pushes into a 16-entry FIFO
        base = iss_q.size();
        mc_rq_stall_in = 1;
        for (int i = 0; i < 17; i++) begin
            ll_write_en_in = 1; ll_address_in = 48'h2000 + 48'(i); ll_payload_in = 64'h6000 + 64'(i);
            tick();
            if (i == 15) check("t4_ovf_16", overflow_out, 0);
        end
        ll_write_en_in = 0;
        check("t4_ovf_17", overflow_out, 1);
        mc_rq_stall_in = 0;
        repeat (20) tick();
        check("t4_issued", 64'(iss_q.size() - base), 16);
        if (iss_q.size() >= base + 16)
            check("t4_last_adr", 64'(iss_q[base + 15].adr), 64'h200F);
        check("t4_ovf_sticky", overflow_out, 1);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd0;
        repeat (16) tick();
        mc_rs_vld_in = 0;
        check("t4_done", done, 1);
        do_reset();
        check("t4_ovf_rst", overflow_out, 0);

        // 20 HT exchanges while the build stage holds off responses
        base = iss_q.size();
        rbase = rsd_q.size();
        pushed = 0;
        resp_n = 0;
        ht_rs_afull_in = 1;
        for (int cyc = 0; cyc < 200 && (rsd_q.size() - rbase) < 20; cyc++) begin
            ht_rq_read_en_in = (pushed < 20);
            ht_rq_address_in = 48'h3000 + 48'(pushed);
            ht_rq_data_in = 64'h7000 + 64'(pushed);
            if (mc_rq_vld_out) begin
                mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd1; mc_rs_data_in = 64'hD000 + 64'(resp_n);
                resp_n++;
            end else begin
                mc_rs_vld_in = 0;
            end
            if (cyc == 60) begin
                check("t5_ht_cap", 64'(resp_n), 16);
                check("t5_none_out", 64'(rsd_q.size() - rbase), 0);
                check("t5_rs_stall", mc_rs_stall_out, 1);
                check("t5_no_ovf", overflow_out, 0);
                ht_rs_afull_in = 0;
            end
            tick();
            if (pushed < 20) pushed++;
        end
        ht_rq_read_en_in = 0;
        mc_rs_vld_in = 0;
        check("t5_delivered", 64'(rsd_q.size() - rbase), 20);
        for (int k = 0; k < 20 && rbase + k < rsd_q.size(); k++)
            check($sformatf("t5_dat%0d", k), rsd_q[rbase + k], 64'hD000 + 64'(k));
        tick();
        check("t5_done", done, 1);
        check("t5_rs_stall_clr", mc_rs_stall_out, 0);

        // Reset with five requests outstanding, then late responses
        base = iss_q.size();
        for (int i = 0; i < 5; i++) begin
            ll_write_en_in = 1; ll_address_in = 48'h4000 + 48'(i); ll_payload_in = 64'h8000 + 64'(i);
            tick();
        end
        ll_write_en_in = 0;
        repeat (4) tick();
        check("t6_issued", 64'(iss_q.size() - base), 5);
        check("t6_busy", done, 0);
        rst = 1'b1;
        ll_write_en_in = 1;
        tick();
        check("t6_rst_done", done, 1);
        check("t6_rst_vld", mc_rq_vld_out, 0);
        check("t6_rst_cmd", mc_rq_cmd_out, 0);
        check("t6_rst_rtn", mc_rq_rtnctl_out, 0);
        check("t6_rst_adr", mc_rq_vadr_out, 0);
        check("t6_rst_dat", mc_rq_data_out, 0);
        check("t6_rst_afull", ll_afull_out, 0);
        check("t6_rst_htrs", ht_rs_write_en_out, 0);
        ll_write_en_in = 0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mc_rs_vld_in = 1; mc_rs_rtnctl_in = (i % 2 == 1) ? 2'd1 : 2'd2; mc_rs_data_in = 64'hBAD;
            tick();
            check($sformatf("t6_late_llrs%0d", i), ll_rs_write_en_out, 0);
        end
        mc_rs_vld_in = 0;
        tick();
        check("t6_late_htrs", ht_rs_write_en_out, 0);
        check("t6_late_done", done, 1);
        ll_write_en_in = 1; ll_address_in = 48'h4100; ll_payload_in = 64'h1;
        tick();
        ll_write_en_in = 0;
        tick();
        check("t6_new_vld", mc_rq_vld_out, 1);
        tick();
        check("t6_new_busy", done, 0);
        mc_rs_vld_in = 1; mc_rs_rtnctl_in = 2'd0;
        tick();
        mc_rs_vld_in = 0;
        check("t6_no_underflow", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
